morse_keyer: RTL and testbench
==============================

Name: morse_keyer

Overview:
Character-level sequencer for the Morse transmitter. It accepts one encoded character (dot/dash pattern plus length) through a valid/ready handshake. It realigns the frequency divider at the start of each character, then counts unit periods from the divider output. It drives the key (tone enable) with standard Morse timing: dot 1, dash 3, intra-character gap 1, inter-character gap 3, word space 7 units.

Parameters:
MAX_LEN, 5, maximum elements per character; width of PATTERN
LEN_W, 3, width of LEN; must hold MAX_LEN
CNT_W, 3, unit counter width; must hold 7

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
TICK_IN  input  1  divider output square wave; each rising edge = one Morse unit
VALID  input  1  character request
READY  output  1  high when a character can be accepted
PATTERN  input  MAX_LEN  element code, bit0 sent first; 1 = dash, 0 = dot
LEN  input  LEN_W  number of elements; 0 = word space
DIV_RST  output  1  one-cycle pulse to reset/realign the divider
KEY  output  1  tone enable to the transmitter
BUSY  output  1  high from accept until completion
DONE  output  1  one-cycle pulse when a character (and its trailing gap) ends

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; KEY = 0, DIV_RST = 0, BUSY = 0, DONE = 0, READY = 1.
  - Internal edge register, unit counter and element index are cleared.
  - Reset mid-character drops KEY at once and abandons the character; no DONE is produced.
- Unit edge u = TICK_IN & ~tick_q, where tick_q is TICK_IN registered every cycle.
  - u is single-cycle. Only u advances unit counters.
  - TICK_IN is already synchronous to CLK.
- Handshake:
  - READY = (state == IDLE). Accept when VALID & READY.
  - On accept, PATTERN and LEN are latched; later input changes are ignored.
  - LEN > MAX_LEN is clamped to MAX_LEN.
  - VALID while not READY is ignored; nothing is queued.
- States (registered outputs; the state entered at edge N drives its outputs from N):
  - IDLE: KEY = 0, BUSY = 0. On accept go to ALIGN.
  - ALIGN: exactly 1 cycle. DIV_RST = 1, BUSY = 1. The counter is cleared and any u in this cycle is ignored. Go to WORD_GAP if LEN == 0, else to MARK.
  - MARK: KEY = 1. The target is 3 units if PATTERN[idx] = 1, else 1 unit. Count u. When the count reaches the target, in that cycle: clear the counter, then go to GAP if idx + 1 < LEN, else go to CHAR_GAP.
  - GAP: KEY = 0 for 1 unit, then idx++ and go to MARK.
  - CHAR_GAP: KEY = 0 for 3 units, then go to IDLE.
  - WORD_GAP: KEY = 0 for 7 units, then go to IDLE.
- Completion:
  - DONE = 1 for exactly the first IDLE cycle after CHAR_GAP or WORD_GAP; BUSY drops the same cycle.
  - READY is high in the DONE cycle, so a back-to-back accept in that cycle is legal.
- KEY timing: KEY changes on the CLK edge following the qualifying u.
  - Mark length in cycles = units × divider period (±0 cycles in steady state).
- A u coinciding with a state transition counts only toward the new state if it occurs in a later cycle; the transition cycle's u is consumed by the old state.
- Counters never wrap: the maximum count of 7 fits CNT_W = 3.

Test Plan:
- Bench setup for all scenarios: TICK_IN is a model of the divider with period 8 cycles, restarted by DIV_RST.
- Reset then idle -> READY = 1, KEY = 0, BUSY = 0, DONE = 0; DIV_RST never pulses without VALID.
- 'A': PATTERN = 5'b00010, LEN = 2 -> DIV_RST for 1 cycle, then KEY high 1 unit (8 cycles), low 8, high 24, low 24. DONE pulses once; BUSY spans the full sequence.
- Word space: LEN = 0 -> DIV_RST pulse, KEY stays 0 for 56 cycles, then DONE.
- 'T' accepted back-to-back with 'E', the second VALID held through the DONE cycle -> second accept occurs in the DONE cycle. KEY shows 24 high, 24 low, DIV_RST, 8 high, 24 low.
- VALID with LEN = 7 (> MAX_LEN), PATTERN = 5'b11111 -> exactly 5 dashes are sent; VALID pulses while BUSY are ignored.
- Assert RST during the second dash of 'O' (5'b00111, LEN = 3) -> KEY = 0 immediately and READY = 1; no DONE. The next character sends correctly from a fresh DIV_RST.

Source files
------------

// File: rtl/morse_keyer.sv
// Morse character sequencer.
// Accepts one dot/dash pattern per valid/ready handshake and realigns the
// external frequency divider at the start of each character. It then keys
// the transmitter in whole Morse units: dot 1, dash 3, element gap 1,
// character gap 3, word space 7. A unit is one rising edge of TICK_IN.
module morse_keyer #(
  parameter int MAX_LEN = 5,  // maximum elements per character
  parameter int LEN_W   = 3,  // width of LEN, must hold MAX_LEN
  parameter int CNT_W   = 3   // unit counter width, must hold 7
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               TICK_IN,
  input  logic               VALID,
  output logic               READY,
  input  logic [MAX_LEN-1:0] PATTERN,
  input  logic [LEN_W-1:0]   LEN,
  output logic               DIV_RST,
  output logic               KEY,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    MARK,
    GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t               state_q, state_d;
  logic                 tick_q, tick_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 key_q, key_d;
  logic                 div_rst_q, div_rst_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  logic                 unit;
  logic                 last_unit;
  logic                 more_elems;
  logic [CNT_W-1:0]     target;
  logic [LEN_W:0]       idx_next_w;

  // Next-state, counters and registered-output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pat_d      = pat_q;
    len_d      = len_q;
    tick_d     = TICK_IN;
    target     = CNT_ONE;

    // Single-cycle unit strobe from the divider's rising edge.
    unit       = TICK_IN & ~tick_q;

    idx_next_w = {1'b0, idx_q} + (LEN_W + 1)'(1);
    more_elems = idx_next_w < {1'b0, len_q};

    // Units required in the current state.
    case (state_q)
      MARK:     target = pat_q[idx_q] ? CNT_W'(3) : CNT_W'(1);
      GAP:      target = CNT_W'(1);
      CHAR_GAP: target = CNT_W'(3);
      WORD_GAP: target = CNT_W'(7);
      default:  target = CNT_ONE;
    endcase

    last_unit = unit && ((cnt_q + CNT_ONE) == target);

    case (state_q)
      IDLE: begin
        if (VALID) begin
          pat_d   = PATTERN;
          len_d   = (LEN > LEN_MAX) ? LEN_MAX : LEN;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        // The divider restarts this cycle; a unit seen now belongs to no one.
        cnt_d   = '0;
        state_d = (len_q == '0) ? WORD_GAP : MARK;
      end
      MARK, GAP, CHAR_GAP, WORD_GAP: begin
        if (last_unit) begin
          cnt_d = '0;
          case (state_q)
            MARK:    state_d = more_elems ? GAP : CHAR_GAP;
            GAP: begin
              idx_d   = idx_q + LEN_W'(1);
              state_d = MARK;
            end
            default: state_d = IDLE;
          endcase
        end else if (unit) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the state being entered, so they line up
    // with the state register cycle for cycle.
    key_d     = (state_d == MARK);
    div_rst_d = (state_d == ALIGN);
    busy_d    = (state_d != IDLE);
    ready_d   = (state_d == IDLE);
    done_d    = ((state_q == CHAR_GAP) || (state_q == WORD_GAP)) &&
                (state_d == IDLE);
  end

  // State, datapath and output registers; reset abandons any character.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      key_q     <= 1'b0;
      div_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q   <= state_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      key_q     <= key_d;
      div_rst_q <= div_rst_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign READY   = ready_q;
  assign DIV_RST = div_rst_q;
  assign KEY     = key_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer. A divider model with an 8-cycle period
// feeds TICK_IN; KEY is captured as run lengths per character and compared
// with hand-computed unit timings (1 unit = 8 cycles).
module tb_morse_keyer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TICK_IN;
  logic       VALID;
  logic       READY;
  logic [4:0] PATTERN;
  logic [2:0] LEN;
  logic       DIV_RST;
  logic       KEY;
  logic       BUSY;
  logic       DONE;

  int n_checks = 0;
  int n_errors = 0;

  int exp_runs[$];
  int got_runs[$];

  morse_keyer #(.MAX_LEN(5), .LEN_W(3), .CNT_W(3)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .TICK_IN (TICK_IN),
    .VALID   (VALID),
    .READY   (READY),
    .PATTERN (PATTERN),
    .LEN     (LEN),
    .DIV_RST (DIV_RST),
    .KEY     (KEY),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  // Divider model: period 8, 50% duty. DIV_RST starts a fresh period whose
  // rising edge is the DIV_RST cycle itself, so the next rising edge comes
  // 8 cycles later.
  logic [2:0] div_cnt = 3'd0;
  always @(posedge CLK) begin
    if (DIV_RST) div_cnt <= 3'd1;
    else         div_cnt <= div_cnt + 3'd1;
  end
  assign TICK_IN = DIV_RST | (div_cnt < 3'd4);

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a character; returns at the negedge of the ALIGN cycle.
  task automatic start(input logic [4:0] p, input logic [2:0] l);
    @(negedge CLK);
    VALID   = 1'b1;
    PATTERN = p;
    LEN     = l;
    @(negedge CLK);
  endtask

  // Called in the ALIGN cycle. Records KEY run lengths up to DONE and
  // compares them with exp_runs. With noise set, VALID is pulsed while busy.
  task automatic capture(input string tag, input logic exp_first, input bit noise);
    logic cur_lvl;
    logic first_lvl;
    int   cur_len;
    bit   done_seen;
    int   div_extra;
    int   busy_low;
    check({tag, " align div_rst"}, int'(DIV_RST), 1);
    check({tag, " align busy"},    int'(BUSY),    1);
    check({tag, " align key"},     int'(KEY),     0);
    check({tag, " align ready"},   int'(READY),   0);
    check({tag, " align done"},    int'(DONE),    0);
    got_runs.delete();
    cur_lvl   = 1'b0;
    first_lvl = 1'b0;
    cur_len   = 0;
    done_seen = 1'b0;
    div_extra = 0;
    busy_low  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (DONE) begin
        done_seen = 1'b1;
        if (noise) VALID = 1'b0;
        break;
      end
      if (noise) begin
        VALID   = ((i % 7) == 3);
        PATTERN = 5'b00000;
        LEN     = 3'd1;
      end
      if (DIV_RST) div_extra++;
      if (!BUSY)   busy_low++;
      if (i == 0) begin
        first_lvl = KEY;
        cur_lvl   = KEY;
        cur_len   = 1;
      end else if (KEY == cur_lvl) begin
        cur_len++;
      end else begin
        got_runs.push_back(cur_len);
        cur_lvl = KEY;
        cur_len = 1;
      end
    end
    if (cur_len != 0) got_runs.push_back(cur_len);
    check({tag, " done seen"},        int'(done_seen), 1);
    check({tag, " first key level"},  int'(first_lvl), int'(exp_first));
    check({tag, " run count"},        got_runs.size(), exp_runs.size());
    for (int k = 0; k < exp_runs.size() && k < got_runs.size(); k++)
      check($sformatf("%s run %0d", tag, k), got_runs[k], exp_runs[k]);
    check({tag, " extra div_rst"},    div_extra, 0);
    check({tag, " busy gaps"},        busy_low,  0);
    check({tag, " done-cycle key"},   int'(KEY),   0);
    check({tag, " done-cycle busy"},  int'(BUSY),  0);
    check({tag, " done-cycle ready"}, int'(READY), 1);
  endtask

  initial begin
    int pulses;
    RST     = 1'b1;
    VALID   = 1'b0;
    PATTERN = '0;
    LEN     = '0;
    repeat (2) @(negedge CLK);
    check("reset ready",   int'(READY),   1);
    check("reset key",     int'(KEY),     0);
    check("reset busy",    int'(BUSY),    0);
    check("reset done",    int'(DONE),    0);
    check("reset div_rst", int'(DIV_RST), 0);
    RST = 1'b0;

    // Idle: nothing may happen without VALID.
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (DIV_RST || DONE || KEY || BUSY || !READY) pulses++;
    end
    check("idle activity", pulses, 0);

    // 'A': dot, dash. Inputs are scrambled after accept to prove latching.
    start(5'b00010, 3'd2);
    VALID   = 1'b0;
    PATTERN = 5'b11111;
    LEN     = 3'd5;
    exp_runs = {8, 8, 24, 24};
    capture("A", 1'b1, 1'b0);
    @(negedge CLK);
    check("A done width", int'(DONE), 0);

    // Word space: 7 silent units.
    start(5'b10101, 3'd0);
    VALID = 1'b0;
    exp_runs = {56};
    capture("word", 1'b0, 1'b0);
    @(negedge CLK);
    check("word done width", int'(DONE), 0);

    // 'T' then 'E' back to back: E's VALID is held from T's ALIGN cycle,
    // ignored while busy, and accepted in T's DONE cycle.
    start(5'b00001, 3'd1);
    PATTERN = 5'b00000;
    LEN     = 3'd1;
    exp_runs = {24, 24};
    capture("T", 1'b1, 1'b0);
    @(negedge CLK);
    VALID = 1'b0;
    exp_runs = {8, 24};
    capture("E b2b", 1'b1, 1'b0);

    // LEN beyond MAX_LEN is clamped: five dashes, noise VALIDs ignored.
    start(5'b11111, 3'd7);
    VALID = 1'b0;
    exp_runs = {24, 8, 24, 8, 24, 8, 24, 8, 24, 24};
    capture("clamp", 1'b1, 1'b1);

    // 'O' interrupted by reset during its second dash (cycles 33..56).
    start(5'b00111, 3'd3);
    VALID = 1'b0;
    repeat (40) @(negedge CLK);
    check("O dash2 key", int'(KEY), 1);
    #2 RST = 1'b1;
    #1;
    check("O rst key",     int'(KEY),     0);
    check("O rst ready",   int'(READY),   1);
    check("O rst busy",    int'(BUSY),    0);
    check("O rst div_rst", int'(DIV_RST), 0);
    @(negedge CLK);
    RST = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE || DIV_RST || KEY) pulses++;
    end
    check("O no done after rst", pulses, 0);

    // Fresh character after the abort.
    start(5'b00000, 3'd1);
    VALID = 1'b0;
    exp_runs = {8, 24};
    capture("E after rst", 1'b1, 1'b0);

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
